// File: rtl/g3_isa_pkg.sv
// g3_isa_pkg: G3 opcode encodings, legality check and fetch state type.
package g3_isa_pkg;
  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_MUL  = 5'b00010,
    OP_LDR  = 5'b00100, OP_STR  = 5'b00101,
    OP_FADD = 5'b01000, OP_FSUB = 5'b01001, OP_FMUL = 5'b01010,
    OP_FLDR = 5'b01100, OP_FSTR = 5'b01101,
    OP_VADD = 5'b10000, OP_VSUB = 5'b10001, OP_VMUL = 5'b10010,
    OP_VLDR = 5'b10100, OP_VSTR = 5'b10101,
    OP_MOVI = 5'b11000, OP_MOVR = 5'b11001,
    OP_CMP  = 5'b11100, OP_B    = 5'b11101, OP_BLT  = 5'b11110
  } opcode_e;
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} fetch_state_e;
  function automatic logic is_legal_opcode(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_LDR, OP_STR,
                      OP_FADD, OP_FSUB, OP_FMUL, OP_FLDR, OP_FSTR,
                      OP_VADD, OP_VSUB, OP_VMUL, OP_VLDR, OP_VSTR,
                      OP_MOVI, OP_MOVR, OP_CMP, OP_B, OP_BLT};
  endfunction
endpackage

// File: rtl/g3_fetch_skid.sv
// g3_fetch_skid: one-entry parking register for a response that arrives while IF/ID is stalled.
module g3_fetch_skid #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               drain_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o
);
  logic valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q;
  logic [INSTR_W-1:0] instr_q;
  assign valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : drain_i ? 1'b0 : valid_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        pc_q    <= pc_i;
        instr_q <= instr_i;
      end
    end
  end
  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;
endmodule

// File: rtl/g3_fetch_unit.sv
// g3_fetch_unit: PC, single-outstanding imem requests and the IF/ID slot feeding decode.
module g3_fetch_unit
  import g3_isa_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic [4:0]         if_opcode,
  output logic               if_illegal
);
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, if_pc_q, if_pc_d, skid_pc;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d, skid_instr;
  logic if_valid_q, if_valid_d, kill_q, kill_d, started_q;
  logic grant, slot_free, skid_load, skid_drain, skid_valid;

  // Requests start one edge after reset release, never while reset is held.
  assign imem_req  = started_q && state_q == S_FETCH;
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;
  assign slot_free = !if_valid_q || !id_stall;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q && id_stall;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (branch_taken) begin
      pc_d       = branch_target & ~ADDR_W'(3);
      if_valid_d = 1'b0;
      // A response landing in the redirect cycle is already dropped, so no kill is owed.
      kill_d     = (state_q == S_WAIT && !imem_rvalid) || (state_q == S_FETCH && grant);
      state_d    = kill_d ? S_WAIT : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: state_d = grant ? S_WAIT : S_FETCH;
        S_WAIT: if (imem_rvalid) begin
          state_d = S_FETCH;
          kill_d  = 1'b0;
          if (!kill_q) begin
            pc_d = pc_q + ADDR_W'(4);
            if (slot_free) begin
              if_valid_d = 1'b1;
              if_pc_d    = pc_q;
              if_instr_d = imem_rdata;
            end else begin
              skid_load = 1'b1;
              state_d   = S_HOLD;
            end
          end
        end
        S_HOLD: if (!id_stall) begin
          if_valid_d = skid_valid;
          if_pc_d    = skid_pc;
          if_instr_d = skid_instr;
          skid_drain = 1'b1;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      started_q  <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      started_q  <= 1'b1;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  g3_fetch_skid #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .flush_i (branch_taken),
    .pc_i    (pc_q),
    .instr_i (imem_rdata),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  assign if_valid   = if_valid_q;
  assign if_pc      = if_pc_q;
  assign if_instr   = if_instr_q;
  assign if_opcode  = if_instr_q[INSTR_W-1 -: 5];
  assign if_illegal = if_valid_q && !is_legal_opcode(if_opcode);
endmodule

// File: tb/tb_g3_fetch_unit.sv
// tb_g3_fetch_unit: directed vectors for g3_fetch_unit with hand-computed expectations.
module tb_g3_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic id_stall = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic if_valid, if_illegal;
  logic [31:0] if_pc, if_instr;
  logic [4:0] if_opcode;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  g3_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .id_stall      (id_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_opcode     (if_opcode),
    .if_illegal    (if_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = w;
    cyc();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_illegal", if_illegal, 0);
    cyc();
    cyc();
    rst = 1'b1;
    chk("rel_req_pre_edge", imem_req, 0);
    cyc();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    cyc();
    chk("wait_req", imem_req, 0);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0;
    cyc();
    imem_rvalid = 1'b0;
    chk("f0_valid", if_valid, 1);
    chk("f0_pc", if_pc, 32'h0);
    chk("f0_opcode", if_opcode, 5'b00000);
    chk("f0_illegal", if_illegal, 0);
    chk("f0_next_addr", imem_addr, 32'h4);
    cyc();
    chk("consume_valid", if_valid, 0);
    chk("nogrant_addr", imem_addr, 32'h4);
    chk("nogrant_req", imem_req, 1);

    id_stall = 1'b1;
    fetch(32'h0800_0001);
    chk("st1_valid", if_valid, 1);
    chk("st1_pc", if_pc, 32'h4);
    fetch(32'h1000_0002);
    chk("hold_req", imem_req, 0);
    chk("hold_slot_pc", if_pc, 32'h4);
    chk("hold_slot_instr", if_instr, 32'h0800_0001);
    cyc();
    chk("hold_req2", imem_req, 0);
    chk("hold_instr2", if_instr, 32'h0800_0001);
    id_stall = 1'b0;
    cyc();
    chk("drain_valid", if_valid, 1);
    chk("drain_pc", if_pc, 32'h8);
    chk("drain_instr", if_instr, 32'h1000_0002);
    chk("drain_addr", imem_addr, 32'hC);
    chk("drain_req", imem_req, 1);
    cyc();
    chk("no_dup_valid", if_valid, 0);

    imem_gnt = 1'b1;
    cyc();
    imem_gnt      = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h103;
    cyc();
    branch_taken = 1'b0;
    chk("br_wait_valid", if_valid, 0);
    chk("br_wait_req", imem_req, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h4000_0000;
    cyc();
    imem_rvalid = 1'b0;
    chk("kill_valid", if_valid, 0);
    chk("kill_req", imem_req, 1);
    chk("kill_addr", imem_addr, 32'h100);

    id_stall = 1'b1;
    fetch(32'h1800_0000);
    chk("ill_valid", if_valid, 1);
    chk("ill_opcode", if_opcode, 5'b00011);
    chk("ill_flag", if_illegal, 1);
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    cyc();
    branch_taken = 1'b0;
    id_stall     = 1'b0;
    chk("brst_valid", if_valid, 0);
    chk("brst_addr", imem_addr, 32'h200);
    chk("brst_req", imem_req, 1);

    fetch(32'hF000_0000);
    chk("blt_valid", if_valid, 1);
    chk("blt_pc", if_pc, 32'h200);
    chk("blt_opcode", if_opcode, 5'b11110);
    chk("blt_illegal", if_illegal, 0);
    fetch(32'h3800_0000);
    chk("op07_pc", if_pc, 32'h204);
    chk("op07_illegal", if_illegal, 1);

    id_stall = 1'b1;
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    chk("pre_rst_valid", if_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", if_valid, 0);
    chk("arst_req", imem_req, 0);
    chk("arst_pc", if_pc, 0);
    chk("arst_illegal", if_illegal, 0);
    cyc();
    rst         = 1'b1;
    id_stall    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hF000_0000;
    cyc();
    imem_rvalid = 1'b0;
    chk("stale_valid", if_valid, 0);
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, 32'h0);
    fetch(32'h2000_0000);
    chk("post_rst_fvalid", if_valid, 1);
    chk("post_rst_fpc", if_pc, 32'h0);
    chk("post_rst_finstr", if_instr, 32'h2000_0000);
    chk("post_rst_addr2", imem_addr, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
